// File: rtl/ring_counter_pkg.sv
// Shared constants and reset-pattern helper for the parametrised ring/Johnson counter.
package ring_counter_pkg;
  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam int   MAX_W        = 64;

  // Callers truncate the result to their own WIDTH; bits above width are always zero.
  function automatic logic [MAX_W-1:0] reset_pattern(input logic m,
                                                     input int unsigned width,
                                                     input int unsigned rpos);
    logic [MAX_W-1:0] p;
    p = '0;
    if (m == MODE_RING && rpos < width) p = MAX_W'(1) << rpos;
    return p;
  endfunction
endpackage

// File: rtl/ring_pos_decode.sv
// Combinational position decode and legality check for ring/Johnson patterns.
module ring_pos_decode
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] out,
  input  logic             mode_q,
  output logic [PW-1:0]    pos,
  output logic             legal
);
  int pc;
  int tr;
  logic [PW-1:0] ring_pos;

  always_comb begin
    pc       = 0;
    tr       = 0;
    ring_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + int'(out[i]);
      if (out[i]) ring_pos = PW'(i);
    end
    for (int i = 0; i < WIDTH-1; i++) tr = tr + int'(out[i] ^ out[i+1]);
  end

  always_comb begin
    pos   = '0;
    legal = 1'b0;
    if (mode_q == MODE_RING) begin
      pos   = ring_pos;
      legal = (pc == 1);
    end else begin
      // Johnson: low half fills from bit 0, high half drains from bit 0.
      if (out == '0)   pos = '0;
      else if (out[0]) pos = PW'(pc);
      else             pos = PW'(2*WIDTH - pc);
      legal = (tr <= 1);
    end
  end
endmodule

// File: rtl/ring_counter_param.sv
// Parametrised ring/Johnson counter with load, self-correction and wrap strobe.
module ring_counter_param
  import ring_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_POS = 0,
  parameter int PW        = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             err
);
  logic [WIDTH-1:0] out_q, out_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             legal;
  logic [PW-1:0]    last_pos;

  ring_pos_decode #(.WIDTH(WIDTH), .PW(PW)) u_dec (
    .out    (out_q),
    .mode_q (mode_q),
    .pos    (pos),
    .legal  (legal)
  );

  function automatic logic [WIDTH-1:0] rst_pat(input logic m);
    return WIDTH'(reset_pattern(m, WIDTH, RESET_POS));
  endfunction

  always_comb begin
    out_d    = out_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    last_pos = (mode_q == MODE_RING) ? PW'(WIDTH-1) : PW'(2*WIDTH-1);
    if (load) begin
      out_d = load_val;
    end else if (mode != mode_q) begin
      mode_d = mode;
      out_d  = rst_pat(mode);
    end else if (!legal) begin
      out_d = rst_pat(mode_q);
      err_d = 1'b1;
    end else if (en) begin
      if (dir == DIR_UP) begin
        out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1] ^ mode_q};
        wrap_d = (pos == last_pos);
      end else begin
        out_d  = {out_q[0] ^ mode_q, out_q[WIDTH-1:1]};
        wrap_d = (pos == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= mode;
      out_q  <= rst_pat(mode);
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign err  = err_q;
endmodule

// File: tb/tb_ring_counter_param.sv
// Directed bench: W=4 counter through ring/Johnson/load/correction, plus W=6 RESET_POS=2.
module tb_ring_counter_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, dir, mode, load;
  logic [3:0] load_val, out;
  logic [2:0] pos;
  logic       wrap, err;

  logic       b_reset, b_en, b_dir, b_mode, b_load;
  logic [5:0] b_load_val, b_out;
  logic [3:0] b_pos;
  logic       b_wrap, b_err;

  int errors = 0;
  int checks = 0;

  ring_counter_param #(.WIDTH(4), .RESET_POS(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .out(out), .pos(pos), .wrap(wrap), .err(err)
  );

  ring_counter_param #(.WIDTH(6), .RESET_POS(2)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .dir(b_dir), .mode(b_mode), .load(b_load),
    .load_val(b_load_val), .out(b_out), .pos(b_pos), .wrap(b_wrap), .err(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    checks++; if (out !== 4'b0001) begin errors++; $display("FAIL reset_out: got %b expected 0001", out); end
    checks++; if (pos !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", pos); end
    checks++; if (wrap !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_strobes: got wrap=%b err=%b expected 0 0", wrap, err); end
  endtask

  task automatic test_ring_up();
    logic [3:0] eo [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] ep [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out !== eo[i] || pos !== ep[i] || wrap !== ew[i]) begin
        errors++; $display("FAIL ring_up[%0d]: got out=%b pos=%0d wrap=%b expected %b %0d %b", i, out, pos, wrap, eo[i], ep[i], ew[i]);
      end
    end
  endtask

  task automatic test_ring_down_hold();
    dir = 1'b1; en = 1'b1; step();
    checks++; if (out !== 4'b1000 || pos !== 3'd3 || wrap !== 1'b1) begin
      errors++; $display("FAIL ring_down: got out=%b pos=%0d wrap=%b expected 1000 3 1", out, pos, wrap);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out !== 4'b1000 || wrap !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got out=%b wrap=%b err=%b expected 1000 0 0", i, out, wrap, err);
      end
    end
  endtask

  task automatic test_johnson();
    logic [3:0] eo [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    mode = 1'b1; en = 1'b0; dir = 1'b0; step();
    checks++; if (out !== 4'b0000 || pos !== 3'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL mode_switch: got out=%b pos=%0d wrap=%b expected 0000 0 0", out, pos, wrap);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (out !== eo[i] || pos !== 3'((i + 1) % 8) || wrap !== (i == 7)) begin
        errors++; $display("FAIL johnson_up[%0d]: got out=%b pos=%0d wrap=%b expected %b %0d %b", i, out, pos, wrap, eo[i], (i + 1) % 8, (i == 7));
      end
    end
    dir = 1'b1; step();
    checks++; if (out !== 4'b1000 || pos !== 3'd7 || wrap !== 1'b1) begin
      errors++; $display("FAIL johnson_down: got out=%b pos=%0d wrap=%b expected 1000 7 1", out, pos, wrap);
    end
    en = 1'b0; load = 1'b1; load_val = 4'b0101; step(); load = 1'b0;
    step();
    checks++; if (out !== 4'b0000 || err !== 1'b1) begin
      errors++; $display("FAIL johnson_fix: got out=%b err=%b expected 0000 1", out, err);
    end
  endtask

  task automatic test_illegal_load();
    mode = 1'b0; en = 1'b0; dir = 1'b0; step();
    checks++; if (out !== 4'b0001 || err !== 1'b0) begin
      errors++; $display("FAIL mode_back: got out=%b err=%b expected 0001 0", out, err);
    end
    load = 1'b1; load_val = 4'b0110; step(); load = 1'b0;
    checks++; if (out !== 4'b0110 || err !== 1'b0) begin
      errors++; $display("FAIL illegal_load: got out=%b err=%b expected 0110 0", out, err);
    end
    step();
    checks++; if (out !== 4'b0001 || err !== 1'b1 || wrap !== 1'b0) begin
      errors++; $display("FAIL ring_fix: got out=%b err=%b wrap=%b expected 0001 1 0", out, err, wrap);
    end
    step();
    checks++; if (out !== 4'b0001 || err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got out=%b err=%b expected 0001 0", out, err);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; dir = 1'b0; load = 1'b1; load_val = 4'b0100; step(); load = 1'b0;
    checks++; if (out !== 4'b0100 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_vs_en: got out=%b wrap=%b expected 0100 0", out, wrap);
    end
    step();
    checks++; if (out !== 4'b1000 || pos !== 3'd3) begin
      errors++; $display("FAIL shift_after_load: got out=%b pos=%0d expected 1000 3", out, pos);
    end
    reset = 1'b1; load = 1'b1; load_val = 4'b0010; step(); reset = 1'b0; load = 1'b0;
    checks++; if (out !== 4'b0001 || wrap !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_vs_load: got out=%b wrap=%b err=%b expected 0001 0 0", out, wrap, err);
    end
    en = 1'b0;
  endtask

  task automatic test_w6_reset_pos();
    logic [5:0] eo [6] = '{6'b001000, 6'b010000, 6'b100000, 6'b000001, 6'b000010, 6'b000100};
    logic [3:0] ep [6] = '{4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2};
    int nwrap = 0;
    b_mode = 1'b0; b_reset = 1'b1; step(); b_reset = 1'b0;
    checks++; if (b_out !== 6'b000100 || b_pos !== 4'd2) begin
      errors++; $display("FAIL w6_reset: got out=%b pos=%0d expected 000100 2", b_out, b_pos);
    end
    b_en = 1'b1; b_dir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b_wrap) nwrap++;
      checks++; if (b_out !== eo[i] || b_pos !== ep[i] || b_wrap !== (i == 3)) begin
        errors++; $display("FAIL w6_step[%0d]: got out=%b pos=%0d wrap=%b expected %b %0d %b", i, b_out, b_pos, b_wrap, eo[i], ep[i], (i == 3));
      end
    end
    checks++; if (nwrap !== 1) begin errors++; $display("FAIL w6_wrap_count: got %0d expected 1", nwrap); end
    b_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    b_reset = 1'b1; b_en = 1'b0; b_dir = 1'b0; b_mode = 1'b0; b_load = 1'b0; b_load_val = '0;
    test_reset();
    test_ring_up();
    test_ring_down_hold();
    test_johnson();
    test_illegal_load();
    test_back_to_back();
    test_w6_reset_pos();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ring_counter_param.md
# ring_counter_param

Parametrised ring/Johnson counter, the next generation of the team's fixed 4-bit ring counter. It supports configurable width, ring (one-hot) or Johnson (twisted-ring) mode, shift direction, clock enable, parallel load, automatic recovery from illegal states, and a wrap strobe. It is intended for sequencers, round-robin pointers and phase generators that need a decoded position index next to the raw pattern.

## Interface
- `WIDTH`, default 4: counter width in bits, must be ≥ 2.
- `RESET_POS`, default 0: bit index of the single 1 after reset in ring mode, range 0..WIDTH-1.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset; highest priority.
- `en` in 1: advance one step on this edge.
- `dir` in 1: 0 = shift toward MSB (pos increments); 1 = shift toward LSB (pos decrements).
- `mode` in 1: 0 = ring, 1 = Johnson.
- `load` in 1: parallel load of `load_val`.
- `load_val` in WIDTH: value to load; not validated at load time.
- `out` out WIDTH: counter register.
- `pos` out $clog2(2*WIDTH): decoded position, combinational from `out`, no added latency.
- `wrap` out 1: registered one-cycle strobe on a boundary-crossing shift.
- `err` out 1: registered one-cycle strobe when an illegal state is corrected.

## Operation
- Internal `mode_q` holds the mode last applied to the counter.
- Priority on each edge: reset > load > mode change > illegal correction > shift > hold.
- Reset:
  - `mode_q` <= `mode`.
  - `out` <= one-hot at `RESET_POS` if `mode`=0, all-zero if `mode`=1.
  - `wrap` <= 0, `err` <= 0.
- Load: `out` <= `load_val`; `mode_q` is unchanged; `wrap` = 0; `err` = 0.
- Mode change (`mode` != `mode_q`, no load):
  - `mode_q` <= `mode`.
  - `out` <= reset pattern of the new mode.
- Legality:
  - Ring mode: `out` is exactly one-hot.
  - Johnson mode: at most one index i in 0..WIDTH-2 with `out[i]` != `out[i+1]`.
- Illegal correction (`out` illegal for `mode_q`):
  - `out` <= reset pattern of `mode_q`; `err` <= 1.
  - Happens regardless of `en`.
- Shift (`en`=1, state legal):
  - Ring: dir=0 gives `{out[W-2:0], out[W-1]}`; dir=1 gives `{out[0], out[W-1:1]}`.
  - Johnson: dir=0 gives `{out[W-2:0], ~out[W-1]}`; dir=1 gives `{~out[0], out[W-1:1]}`.
- `pos` decode:
  - Ring: index of the set bit, 0..W-1.
  - Johnson: 0 if `out`==0; popcount(`out`) if `out[0]`=1; otherwise 2W − popcount(`out`). Range 0..2W-1.
  - Undefined while `out` is illegal; the bench must not check it then.
- Period P = W in ring mode, 2W in Johnson mode.

## Timing
- `out`, `wrap` and `err` are registered and update together; `pos` follows `out` in the same cycle.
- `wrap` = 1 only on a shift edge whose pos moves P-1→0 (dir=0) or 0→P-1 (dir=1). It is 0 after load, mode change, correction and reset.
- `err` = 1 only in the cycle following the correction edge.
- An illegal load is visible on `out` for exactly one cycle, then corrected on the next edge, even if `en`=0, unless load or reset intervenes.
- Simultaneous load and `en`: load wins and no shift occurs. Reset mid-sequence overrides everything.
- Hold (`en`=0, legal, no load or mode change): all registers keep their value; `wrap` and `err` return to 0.

## Structure
- Package `ring_counter_pkg`:
  - `MODE_RING` = 1'b0, `MODE_JOHNSON` = 1'b1.
  - `DIR_UP` = 1'b0, `DIR_DOWN` = 1'b1.
  - Function returning the reset pattern for (mode, WIDTH, RESET_POS).
- Sub-module `ring_pos_decode`, parametrised on WIDTH:
  - Inputs: `out`, `mode_q`.
  - Outputs: `pos`, `legal`.
  - Purely combinational; it is shared by the legality check and the `pos` output.

## Test plan
- W=4, RESET_POS=0, mode=0: reset, then `en`=1 for 4 edges → `out` = 0010, 0100, 1000, 0001; `pos` = 1, 2, 3, 0; `wrap`=1 only with 0001.
- From 0001 with dir=1, one enabled edge → `out`=1000, `pos`=3, `wrap`=1; hold with `en`=0 for 3 cycles → `out` stays 1000, `wrap`=0.
- Switch mode 0→1 → next edge `out`=0000, `pos`=0; 8 enabled edges → 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with `pos` 1..7, 0; `wrap`=1 only at the final 0000.
- Ring mode, load 0110 with `en`=0 → `out`=0110 for one cycle, next edge `out`=0001, `err`=1, then `err`=0.
- Same-cycle events: `load`=1 (`load_val`=0100) with `en`=1 → `out`=0100 with no shift; `reset`=1 with `load`=1 mid-sequence → `out`=0001, `wrap`=0, `err`=0.
- RESET_POS=2, W=6, mode=0: reset → `out`=000100, `pos`=2; 6 enabled edges (dir=0) return to 000100 with exactly one `wrap` pulse, on 000001.
